// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction ROM read port plus the decode valid/ready link.
interface instr_fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  fetch_en;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  rom_read;
   logic [DATA_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  if_valid;
   logic                  if_ready;
   logic [DATA_WIDTH-1:0] if_instr;
   logic [DATA_WIDTH-1:0] if_pc;

   // The fetch unit drives ROM requests and the decode-facing head.
   modport master (
      input  fetch_en, redirect_valid, redirect_pc, rom_data, if_ready,
      output rom_read, rom_addr, if_valid, if_instr, if_pc
   );

   // Environment side: control inputs, the ROM and the decode stage.
   modport slave (
      output fetch_en, redirect_valid, redirect_pc, rom_data, if_ready,
      input  rom_read, rom_addr, if_valid, if_instr, if_pc
   );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency ROM reads and buffers
// {pc, instr} in a small FIFO for decode. Redirects drop in-flight and buffered fetches.
module instr_fetch_unit #(
   parameter int unsigned                  DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]        RESET_PC   = DATA_WIDTH'(32'h0100_0000),
   parameter int unsigned                  FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_fetch_unit_if.master    bus
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic                  pend_q, pend_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         wr_q, wr_d;
   logic [PW-1:0]         rd_q, rd_d;
   logic [DATA_WIDTH-1:0] mem_pc_q    [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_instr_q [FIFO_DEPTH];

   logic                  pop_c;
   logic                  push_c;
   logic                  issue_c;
   logic [OW-1:0]         occ_c;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake terms and the issue rule: only issue when the response is sure to find a slot.
   always_comb begin
      pop_c   = (cnt_q != '0) & bus.if_ready;
      push_c  = pend_q & ~bus.redirect_valid;
      occ_c   = OW'(cnt_q) + OW'(pend_q) - OW'(pop_c);
      issue_c = rst & bus.fetch_en & ~bus.redirect_valid & (occ_c < OW'(FIFO_DEPTH));
   end

   // Next-state for PC, in-flight tracking and FIFO pointers.
   always_comb begin
      pc_d      = pc_q;
      pend_d    = issue_c;
      pend_pc_d = pend_pc_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      if (issue_c) begin
         pc_d      = pc_q + DATA_WIDTH'(4);
         pend_pc_d = pc_q;
      end
      if (bus.redirect_valid) begin
         // A same-cycle pop is consumed by decode; everything else is discarded.
         pc_d  = bus.redirect_pc & ~DATA_WIDTH'(3);
         cnt_d = '0;
         wr_d  = '0;
         rd_d  = '0;
      end else begin
         if (push_c) wr_d = ptr_inc(wr_q);
         if (pop_c)  rd_d = ptr_inc(rd_q);
         cnt_d = CW'(OW'(cnt_q) + OW'(push_c) - OW'(pop_c));
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         cnt_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
      end else begin
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
      end
   end

   // FIFO storage; the ROM response lands at the write pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_pc_q[i]    <= '0;
            mem_instr_q[i] <= '0;
         end
      end else if (push_c) begin
         mem_pc_q[wr_q]    <= pend_pc_q;
         mem_instr_q[wr_q] <= bus.rom_data;
      end
   end

   assign bus.rom_read = issue_c;
   assign bus.rom_addr = pc_q;
   assign bus.if_valid = (cnt_q != '0);
   assign bus.if_instr = mem_instr_q[rd_q];
   assign bus.if_pc    = mem_pc_q[rd_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model, directed scenarios, randomized traffic,
// and a scoreboard that expects a contiguous address stream restarted by each redirect.
module tb_instr_fetch_unit;

   localparam int unsigned DW       = 32;
   localparam logic [31:0] RESET_PC = 32'h0100_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;

   instr_fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

   instr_fetch_unit #(
      .DATA_WIDTH(DW),
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   int          errors = 0;
   int          checks = 0;
   int          pops   = 0;
   bit          saw_zero = 1'b0;
   ent_t        exp_q[$];
   logic [31:0] next_pc  = RESET_PC;
   logic [31:0] issue_pc = RESET_PC;
   bit          hold_v   = 1'b0;
   logic [31:0] hold_pc, hold_instr;

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ROM: data for the address read at this edge appears in the following cycle; junk otherwise.
   always @(posedge clk) begin
      if (bus.rom_read) bus.rom_data <= rom_fn(bus.rom_addr);
      else              bus.rom_data <= $urandom();
   end

   // Monitor: samples mid-cycle, checks issue addresses, head stability and delivered order.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         next_pc  = RESET_PC;
         issue_pc = RESET_PC;
         hold_v   = 1'b0;
      end else begin
         if (hold_v) begin
            chkb("hold_valid", bus.if_valid, 1'b1);
            chk("hold_pc", bus.if_pc, hold_pc);
            chk("hold_instr", bus.if_instr, hold_instr);
         end
         if (bus.redirect_valid || !bus.fetch_en)
            chkb("no_issue", bus.rom_read, 1'b0);
         if (bus.rom_read) begin
            chk("issue_addr", bus.rom_addr, issue_pc);
            issue_pc = issue_pc + 32'd4;
         end
         if (bus.if_valid && bus.if_ready) begin
            ent_t e;
            if (exp_q.size() == 0) begin
               exp_q.push_back('{pc: next_pc, instr: rom_fn(next_pc)});
               next_pc = next_pc + 32'd4;
            end
            e = exp_q.pop_front();
            chk("out_pc", bus.if_pc, e.pc);
            chk("out_instr", bus.if_instr, e.instr);
            if (bus.if_pc == 32'h0) saw_zero = 1'b1;
            pops++;
         end
         hold_v     = bus.if_valid && !bus.if_ready && !bus.redirect_valid;
         hold_pc    = bus.if_pc;
         hold_instr = bus.if_instr;
         if (bus.redirect_valid) begin
            exp_q.delete();
            next_pc  = bus.redirect_pc & ~32'd3;
            issue_pc = bus.redirect_pc & ~32'd3;
         end
      end
   end

   task automatic redirect_to(input logic [31:0] target);
      @(posedge clk); #1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
   endtask

   initial begin
      bus.fetch_en       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.if_ready       = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chkb("rst_read", bus.rom_read, 1'b0);
      chkb("rst_valid", bus.if_valid, 1'b0);
      chk("rst_instr", bus.if_instr, 32'h0);
      chk("rst_pc", bus.if_pc, 32'h0);
      chk("rst_addr", bus.rom_addr, RESET_PC);

      // T1: release and stream
      @(posedge clk); #1;
      rst = 1'b1; bus.fetch_en = 1'b1; bus.if_ready = 1'b1;
      @(negedge clk);
      chkb("t1_read0", bus.rom_read, 1'b1);
      chk("t1_addr0", bus.rom_addr, RESET_PC);
      chkb("t1_valid0", bus.if_valid, 1'b0);
      @(negedge clk);
      chk("t1_addr1", bus.rom_addr, RESET_PC + 32'd4);
      chkb("t1_valid1", bus.if_valid, 1'b0);
      @(negedge clk);
      chkb("t1_valid2", bus.if_valid, 1'b1);
      chk("t1_pc2", bus.if_pc, RESET_PC);
      chk("t1_instr2", bus.if_instr, rom_fn(RESET_PC));
      repeat (5) begin
         @(negedge clk);
         chkb("t1_stream", bus.if_valid, 1'b1);
      end

      // T2: backpressure saturates the buffer
      @(posedge clk); #1; bus.if_ready = 1'b0;
      repeat (5) @(negedge clk);
      chkb("t2_noissue", bus.rom_read, 1'b0);
      chkb("t2_valid", bus.if_valid, 1'b1);
      @(posedge clk); #1; bus.if_ready = 1'b1;
      repeat (6) @(negedge clk);

      // T3/T4: redirect while streaming (same-cycle pop)
      redirect_to(32'h0100_0042);
      @(negedge clk);
      chkb("t3_block", bus.rom_read, 1'b0);
      @(posedge clk); #1; bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t3_addr", bus.rom_addr, 32'h0100_0040);
      chkb("t3_read", bus.rom_read, 1'b1);
      chkb("t3_flush", bus.if_valid, 1'b0);
      @(negedge clk);
      chkb("t3_flush2", bus.if_valid, 1'b0);
      @(negedge clk);
      chkb("t3_valid", bus.if_valid, 1'b1);
      chk("t3_pc", bus.if_pc, 32'h0100_0040);
      repeat (4) @(negedge clk);

      // Redirect with a full buffer, back-to-back: last one wins
      @(posedge clk); #1; bus.if_ready = 1'b0;
      repeat (4) @(negedge clk);
      redirect_to(32'h0200_0000);
      redirect_to(32'h0300_0011);
      @(posedge clk); #1; bus.redirect_valid = 1'b0; bus.if_ready = 1'b1;
      @(negedge clk);
      chk("t3c_addr", bus.rom_addr, 32'h0300_0010);
      repeat (6) @(negedge clk);

      // T5: fetch_en low drains, then resumes
      @(posedge clk); #1; bus.fetch_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chkb("t5_noread", bus.rom_read, 1'b0);
      end
      @(negedge clk);
      chkb("t5_drained", bus.if_valid, 1'b0);
      @(posedge clk); #1; bus.fetch_en = 1'b1;
      repeat (6) @(negedge clk);

      // PC wrap through zero
      redirect_to(32'hFFFF_FFF3);
      @(posedge clk); #1; bus.redirect_valid = 1'b0;
      repeat (12) @(negedge clk);
      chkb("wrap_zero", saw_zero, 1'b1);

      // T6: asynchronous reset between edges
      @(posedge clk); #3; rst = 1'b0;
      #1;
      chkb("t6_read", bus.rom_read, 1'b0);
      chkb("t6_valid", bus.if_valid, 1'b0);
      chk("t6_instr", bus.if_instr, 32'h0);
      chk("t6_pc", bus.if_pc, 32'h0);
      chk("t6_addr", bus.rom_addr, RESET_PC);
      repeat (2) @(negedge clk);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chkb("t6_read1", bus.rom_read, 1'b1);
      chk("t6_addr1", bus.rom_addr, RESET_PC);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         bus.fetch_en       = ($urandom_range(0, 9) != 0);
         bus.if_ready       = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 15) == 0);
         bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : 32'($urandom());
      end
      @(posedge clk); #1;
      bus.redirect_valid = 1'b0; bus.fetch_en = 1'b1; bus.if_ready = 1'b1;
      repeat (5) @(negedge clk);
      chkb("pops_min", (pops > 1000), 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
